// File: rtl/hdr_insert_pkg.sv
// Shared types and keep/popcount helpers for the AXI-Stream header inserter.
// Helpers operate on MAX_BYTES-wide vectors; callers size-cast to their lane count.
package hdr_insert_pkg;

  localparam int unsigned MAX_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    TAIL
  } state_t;

  typedef logic [MAX_BYTES-1:0]   keep_max_t;
  typedef logic [MAX_BYTES*8-1:0] data_max_t;

  function automatic int unsigned popcount(input keep_max_t k);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (k[i]) c++;
    end
    return c;
  endfunction

  // cnt ones starting at lane 0
  function automatic keep_max_t lsb_mask(input int unsigned cnt);
    keep_max_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < cnt);
    end
    return m;
  endfunction

  // cnt ones ending at lane n-1 of an n-lane bus
  function automatic keep_max_t msb_mask(input int unsigned cnt, input int unsigned n);
    keep_max_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < n) && (i + cnt >= n);
    end
    return m;
  endfunction

  function automatic data_max_t byte_mask(input keep_max_t k);
    data_max_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i*8 +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/hdr_byte_merge.sv
// Combinational byte shifter: places H residue bytes ahead of the top N-H payload bytes
// and extracts the low H payload bytes as the next residue.
module hdr_byte_merge
  import hdr_insert_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0]      residue,
  input  logic [DATA_WIDTH-1:0]      payload,
  input  logic [$clog2(N+1)-1:0]     h,
  input  logic [$clog2(N+1)-1:0]     p,
  output logic [DATA_WIDTH-1:0]      merged,
  output logic [DATA_WIDTH-1:0]      next_residue,
  output logic                       overflow
);

  always_comb begin
    // shifts of a full bus width yield zero, covering H=0 and H=N
    merged       = (residue << ((N - 32'(h)) * 8)) | (payload >> (32'(h) * 8));
    next_residue = payload & DATA_WIDTH'(byte_mask(lsb_mask(32'(h))));
    overflow     = (32'(h) + 32'(p)) > N;
  end

endmodule

// File: rtl/axis_header_inserter.sv
// Prepends a 0..N-byte header to each AXI-Stream packet, shifting payload bytes behind it.
// Optional sticky keep-legality flag err_keep when HDR_KEEP_CHECK_EN is defined.
module axis_header_inserter
  import hdr_insert_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_BYTE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_out,
  input  logic                       valid_insert,
  input  logic [DATA_WIDTH-1:0]      data_insert,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_insert,
  output logic                       ready_insert,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_in
`ifdef HDR_KEEP_CHECK_EN
  ,output logic                      err_keep
`endif
);

  localparam int unsigned N  = DATA_BYTE_WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] residue;
  logic [CW-1:0]         h;
  logic [N-1:0]          tail_keep;

  logic                  ld, hdr_acc, pay_acc;
  logic [CW-1:0]         h_in, p_in;
  logic [DATA_WIDTH-1:0] merged, next_residue;
  logic                  overflow;

  logic                  out_load, last_n;
  logic [N-1:0]          keep_n;
  logic [DATA_WIDTH-1:0] data_raw, data_n;

  assign ld           = !valid_out | ready_in;
  assign ready_out    = (state == HEAD) & ld & !rst;
  assign ready_insert = (state == IDLE) & !rst;
  assign hdr_acc      = valid_insert & ready_insert;
  assign pay_acc      = valid_in & ready_out;
  assign h_in         = CW'(popcount(MAX_BYTES'(keep_insert)));
  assign p_in         = CW'(popcount(MAX_BYTES'(keep_in)));

  hdr_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_merge (
    .residue      (residue),
    .payload      (data_in),
    .h            (h),
    .p            (p_in),
    .merged       (merged),
    .next_residue (next_residue),
    .overflow     (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    out_load = 1'b0;
    keep_n   = '0;
    last_n   = 1'b0;
    data_raw = '0;
    case (state)
      IDLE: if (hdr_acc) state_n = HEAD;
      HEAD: if (pay_acc) begin
        out_load = 1'b1;
        data_raw = merged;
        keep_n   = '1;
        if (last_in) begin
          if (overflow) begin
            state_n = TAIL;
          end else begin
            keep_n  = N'(msb_mask(32'(h) + 32'(p_in), N));
            last_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      TAIL: if (ld) begin
        out_load = 1'b1;
        data_raw = residue << ((N - 32'(h)) * 8);
        keep_n   = tail_keep;
        last_n   = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign data_n = data_raw & DATA_WIDTH'(byte_mask(MAX_BYTES'(keep_n)));

  always_ff @(posedge clk) begin
    if (rst) begin
      residue   <= '0;
      h         <= '0;
      tail_keep <= '0;
    end else begin
      if (hdr_acc) begin
        h       <= h_in;
        residue <= data_insert & DATA_WIDTH'(byte_mask(lsb_mask(32'(h_in))));
      end
      if (pay_acc) residue <= next_residue;
      if (pay_acc & last_in & overflow)
        tail_keep <= N'(msb_mask(32'(h) + 32'(p_in) - N, N));
    end
  end

  // Idle output slots are zeroed so unused lanes never carry stale bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (out_load) begin
      valid_out <= 1'b1;
      data_out  <= data_n;
      keep_out  <= keep_n;
      last_out  <= last_n;
    end else if (ld) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end
  end

`ifdef HDR_KEEP_CHECK_EN
  logic bad_pay, bad_hdr;

  assign bad_pay = pay_acc & (last_in ? ((keep_in == '0) || (keep_in != N'(msb_mask(32'(p_in), N))))
                                      : (keep_in != '1));
  assign bad_hdr = hdr_acc & (keep_insert != N'(lsb_mask(32'(h_in))));

  always_ff @(posedge clk) begin
    if (rst)                    err_keep <= 1'b0;
    else if (bad_pay | bad_hdr) err_keep <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_axis_header_inserter.sv
// Directed self-checking bench for axis_header_inserter (DATA_WIDTH=32).
module tb_axis_header_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, last_in, ready_out;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic        valid_out, last_out, ready_in;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
`ifdef HDR_KEEP_CHECK_EN
  logic        err_keep;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t q[$];
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  logic  rand_ready = 1'b0;
  int    checks     = 0;
  int    failures   = 0;
  int    stab_err   = 0;

  always #5 clk = ~clk;

  axis_header_inserter #(
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_out    (ready_out),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .keep_insert  (keep_insert),
    .ready_insert (ready_insert),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_in     (ready_in)
`ifdef HDR_KEEP_CHECK_EN
    ,.err_keep    (err_keep)
`endif
  );

  always @(posedge clk) begin
    #1;
    ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: records transfers and flags any change while stalled.
  always @(negedge clk) begin
    if (prev_stall && (valid_out !== 1'b1 || {data_out, keep_out, last_out} !== prev_beat))
      stab_err++;
    if (valid_out === 1'b1 && ready_in === 1'b1)
      q.push_back({data_out, keep_out, last_out});
    prev_stall = (valid_out === 1'b1) && (ready_in !== 1'b1);
    prev_beat  = {data_out, keep_out, last_out};
  end

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k, output bit ok);
    bit acc;
    ok = 1'b0;
    @(negedge clk);
    valid_insert = 1'b1; data_insert = d; keep_insert = k;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 acc = ready_insert;
      @(posedge clk);
      if (acc) ok = 1'b1;
      else @(negedge clk);
    end
    #1 valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output bit ok);
    bit acc;
    ok = 1'b0;
    @(negedge clk);
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1 acc = ready_out;
      @(posedge clk);
      if (acc) ok = 1'b1;
      else @(negedge clk);
    end
    #1 valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] hd, input logic [3:0] hk,
                          input logic [31:0] pd[2], input logic [3:0] pk[2], input int n,
                          output bit ok);
    bit b;
    send_hdr(hd, hk, ok);
    for (int i = 0; i < n; i++) begin
      send_beat(pd[i], pk[i], (i == n - 1), b);
      ok = ok & b;
    end
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int i = 0; i < 500 && q.size() < n; i++) begin
      @(posedge clk); #2;
    end
    ok = (q.size() >= n);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_in = 1'b0; valid_insert = 1'b0; last_in = 1'b0;
    data_in = '0; keep_in = '0; data_insert = '0; keep_insert = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (ready_out !== 1'b0 || ready_insert !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got ro=%b ri=%b exp 0 0", ready_out, ready_insert);
    end
    rst = 1'b0; #1;
    checks++;
    if ({valid_out, data_out, keep_out, last_out} !== '0) begin
      failures++;
      $display("FAIL reset_out got v=%b d=%h k=%b l=%b exp all 0", valid_out, data_out, keep_out, last_out);
    end
    checks++;
    if (ready_insert !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_insert got %b exp 1", ready_insert);
    end
    q.delete();
  endtask

  task automatic run_basic(input string tag);
    logic [31:0] pd[2] = '{32'h11223344, 32'h55667788};
    logic [3:0]  pk[2] = '{4'b1111, 4'b1111};
    beat_t exp[3] = '{'{32'hCCDD1122, 4'b1111, 1'b0},
                      '{32'h33445566, 4'b1111, 1'b0},
                      '{32'h77880000, 4'b1100, 1'b1}};
    bit ok, okw;
    q.delete();
    send_pkt(32'hAABBCCDD, 4'b0011, pd, pk, 2, ok);
    wait_beats(3, okw);
    checks++;
    if (!(ok && okw) || q.size() != 3) begin
      failures++;
      $display("FAIL %s_count got %0d beats (hs=%b) exp 3", tag, q.size(), ok);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        failures++;
        $display("FAIL %s_beat%0d got %h exp %h", tag, i, (q.size() > i) ? q[i] : '0, exp[i]);
      end
    end
  endtask

  task automatic test_basic;
    run_basic("t1");
  endtask

  task automatic test_no_tail;
    logic [31:0] pd[2] = '{32'h11223300, 32'h0};
    logic [3:0]  pk[2] = '{4'b1110, 4'b0};
    beat_t exp = '{32'hDD112233, 4'b1111, 1'b1};
    bit ok, okw;
    q.delete();
    send_pkt(32'h000000DD, 4'b0001, pd, pk, 1, ok);
    wait_beats(1, okw);
    checks++;
    if (!(ok && okw) || q.size() != 1) begin
      failures++;
      $display("FAIL t2_count got %0d beats exp 1", q.size());
    end
    checks++;
    if (q.size() < 1 || q[0] !== exp) begin
      failures++;
      $display("FAIL t2_beat got %h exp %h", (q.size() > 0) ? q[0] : '0, exp);
    end
  endtask

  task automatic test_backpressure;
    int s0;
    s0 = stab_err;
    rand_ready = 1'b1;
    run_basic("t3");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (stab_err !== s0) begin
      failures++;
      $display("FAIL t3_stable got %0d changes while stalled exp 0", stab_err - s0);
    end
  endtask

  task automatic test_no_header;
    logic [31:0] pd[2] = '{32'h01020304, 32'h05060000};
    logic [3:0]  pk[2] = '{4'b1111, 4'b1100};
    beat_t exp[2] = '{'{32'h01020304, 4'b1111, 1'b0},
                      '{32'h05060000, 4'b1100, 1'b1}};
    bit ok, okw;
    q.delete();
    send_pkt(32'h12345678, 4'b0000, pd, pk, 2, ok);
    wait_beats(2, okw);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!(ok && okw) || q.size() != 2 || q[i] !== exp[i]) begin
        failures++;
        $display("FAIL t4_beat%0d got %h exp %h (n=%0d)", i, (q.size() > i) ? q[i] : '0, exp[i], q.size());
      end
    end
  endtask

  task automatic test_full_header;
    logic [31:0] pd[2] = '{32'h11000000, 32'h0};
    logic [3:0]  pk[2] = '{4'b1000, 4'b0};
    beat_t exp[2] = '{'{32'hAABBCCDD, 4'b1111, 1'b0},
                      '{32'h11000000, 4'b1000, 1'b1}};
    bit ok, okw;
    q.delete();
    send_pkt(32'hAABBCCDD, 4'b1111, pd, pk, 1, ok);
    wait_beats(2, okw);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!(ok && okw) || q.size() != 2 || q[i] !== exp[i]) begin
        failures++;
        $display("FAIL t5_beat%0d got %h exp %h (n=%0d)", i, (q.size() > i) ? q[i] : '0, exp[i], q.size());
      end
    end
  endtask

  task automatic test_mid_reset;
    bit ok, b;
    q.delete();
    send_hdr(32'hAABBCCDD, 4'b0011, ok);
    send_beat(32'h11223344, 4'b1111, 1'b0, b);
    ok = ok & b;
    send_beat(32'h55667788, 4'b1111, 1'b1, b);
    ok = ok & b;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (!ok || valid_out !== 1'b0 || ready_insert !== 1'b1) begin
      failures++;
      $display("FAIL t6_after_rst got v=%b ri=%b hs=%b exp v=0 ri=1", valid_out, ready_insert, ok);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL t6_no_tail got valid_out=%b exp 0", valid_out);
    end
    run_basic("t6");
  endtask

`ifdef HDR_KEEP_CHECK_EN
  task automatic test_err_keep;
    bit ok, b, okw;
    checks++;
    if (err_keep !== 1'b0) begin
      failures++;
      $display("FAIL err_initial got %b exp 0", err_keep);
    end
    q.delete();
    send_hdr(32'hAABBCCDD, 4'b0011, ok);
    send_beat(32'h11223344, 4'b0111, 1'b0, b);
    @(negedge clk);
    checks++;
    if (err_keep !== 1'b1) begin
      failures++;
      $display("FAIL err_set got %b exp 1", err_keep);
    end
    send_beat(32'h55667788, 4'b1111, 1'b1, b);
    wait_beats(3, okw);
    checks++;
    if (err_keep !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b exp 1", err_keep);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (err_keep !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got %b exp 0", err_keep);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_no_tail();
    test_backpressure();
    test_no_header();
    test_full_header();
    test_mid_reset();
`ifdef HDR_KEEP_CHECK_EN
    test_err_keep();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
